ifetch_unit: RTL

Instruction fetch stage placed directly upstream of the single-cycle `cpu` core. It owns the program counter, issues one instruction-memory read at a time over a valid/ready request channel, and holds each returned instruction on a valid/ready output until the core accepts it. The core's branch decision (`pc_sel`, `imm16`) is sampled at the accept handshake to compute the next PC.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/ifetch_unit_pc_next.sv | 19 +
 rtl/ifetch_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, instruction width, reset PC and branch offset helper.
// Pure declarations; no logic, no latency.
package cpu_pkg;

  localparam int unsigned INST_W = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_t;

  // Word offset to byte offset: sign-extend imm16 and scale by 4.
  function automatic logic [31:0] imm16_to_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_unit_pc_next.sv
// Next-PC adder: sequential (pc+4) or taken branch (pc+4+sext(imm16)<<2), modulo 2^32.
// Purely combinational, zero latency, no flow control.
module pc_next
  import cpu_pkg::*;
(
  input  logic [31:0] i_inst_pc,
  input  logic        i_pc_sel,
  input  logic [15:0] i_imm16,
  output logic [31:0] o_pc_next
);

  logic [31:0] w_seq_pc;
  logic [31:0] w_offset;

  assign w_seq_pc  = i_inst_pc + 32'd4;
  assign w_offset  = i_pc_sel ? imm16_to_offset(i_imm16) : 32'd0;
  assign o_pc_next = w_seq_pc + w_offset;

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch: one outstanding imem read, result held on a valid/ready port; 3 cycles/inst at zero wait.
// Requests stall while imem_req_ready is low; the held instruction stalls while inst_ready is low.
module ifetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [31:0]       imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [INST_W-1:0] inst,
  output logic [31:0]       inst_pc,
  input  logic              inst_ready,
  input  logic              pc_sel,
  input  logic [15:0]       imm16,
  input  logic              halt,
  output logic [CNT_W-1:0]  fetch_cnt,
  output logic              err
);

  localparam logic [31:0] RESET_PC_AL = {RESET_PC[31:2], 2'b00};

  fetch_state_t      r_state;
  logic [31:0]       r_pc;
  logic              r_req_vld;
  logic              r_inst_vld;
  logic [INST_W-1:0] r_inst;
  logic [31:0]       r_inst_pc;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic [31:0]       w_pc_next;

  pc_next u_pc_next (
    .i_inst_pc (r_inst_pc),
    .i_pc_sel  (pc_sel),
    .i_imm16   (imm16),
    .o_pc_next (w_pc_next)
  );

  // r_pc only moves at the HOLD handshake, which keeps the request address stable until accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC_AL;
      r_req_vld  <= 1'b0;
      r_inst_vld <= 1'b0;
      r_inst     <= '0;
      r_inst_pc  <= RESET_PC_AL;
      r_cnt      <= '0;
      r_err      <= 1'b0;
    end else begin
      if (imem_rsp_valid && (r_state != ST_WAIT)) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (!halt) begin
            r_state   <= ST_REQ;
            r_req_vld <= 1'b1;
          end
        end
        ST_REQ: begin
          if (imem_req_ready) begin
            r_state   <= ST_WAIT;
            r_req_vld <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (imem_rsp_valid) begin
            r_state    <= ST_HOLD;
            r_inst     <= imem_rsp_data;
            r_inst_pc  <= r_pc;
            r_inst_vld <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (inst_ready) begin
            r_inst_vld <= 1'b0;
            r_pc       <= w_pc_next;
            r_cnt      <= r_cnt + CNT_W'(1);
            if (halt) begin
              r_state <= ST_IDLE;
            end else begin
              r_state   <= ST_REQ;
              r_req_vld <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_req_vld  <= 1'b0;
          r_inst_vld <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = r_req_vld;
  assign imem_req_addr  = r_pc;
  assign inst_valid     = r_inst_vld;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  assign fetch_cnt      = r_cnt;
  assign err            = r_err;

endmodule
